// File: rtl/srv32_dmem_wbuf.sv
// ============================================================================
//  Module      : srv32_dmem_wbuf
//  Description : Posted-write buffer on the srv32 data-memory path; in-order
//                store drain, loads held while they hit a pending store word.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module srv32_dmem_wbuf #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       c_wreq,
    output logic                       c_wack,
    input  logic [AW-1:0]              c_waddr,
    input  logic [DW-1:0]              c_wdata,
    input  logic [DW/8-1:0]            c_wstrb,
    input  logic                       c_rreq,
    output logic                       c_rack,
    input  logic [AW-1:0]              c_raddr,
    output logic                       c_rvalid,
    output logic [DW-1:0]              c_rdata,
    output logic                       m_wreq,
    input  logic                       m_wack,
    output logic [AW-1:0]              m_waddr,
    output logic [DW-1:0]              m_wdata,
    output logic [DW/8-1:0]            m_wstrb,
    output logic                       m_rreq,
    input  logic                       m_rack,
    output logic [AW-1:0]              m_raddr,
    input  logic                       m_rvalid,
    input  logic [DW-1:0]              m_rdata,
    output logic [$clog2(DEPTH+1)-1:0] wbuf_count,
    output logic                       wbuf_empty
);

    localparam int c_SW = DW / 8;
    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);

    logic [AW-1:0]   r_addr [DEPTH];
    logic [DW-1:0]   r_data [DEPTH];
    logic [c_SW-1:0] r_strb [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_rptr;
    logic [c_CW-1:0] r_count;

    logic w_enq;
    logic w_deq;
    logic w_hazard;

    // Acceptance looks only at registered occupancy: no same-cycle refill when full.
    assign c_wack     = (r_count != c_CW'(DEPTH));
    assign m_wreq     = (r_count != '0);
    assign w_enq      = c_wreq & c_wack;
    assign w_deq      = m_wreq & m_wack;

    assign m_waddr    = r_addr[r_rptr];
    assign m_wdata    = r_data[r_rptr];
    assign m_wstrb    = r_strb[r_rptr];
    assign wbuf_count = r_count;
    assign wbuf_empty = (r_count == '0);

    // Word-granular match; strobes are deliberately ignored.
    always_comb begin
        w_hazard = w_enq & (c_waddr[AW-1:2] == c_raddr[AW-1:2]);
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_addr[i][AW-1:2] == c_raddr[AW-1:2])) begin
                w_hazard = 1'b1;
            end
        end
    end

    assign m_rreq   = c_rreq & ~w_hazard;
    assign c_rack   = m_rreq & m_rack;
    assign m_raddr  = c_raddr;
    assign c_rvalid = m_rvalid;
    assign c_rdata  = m_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
                r_strb[i] <= '0;
            end
            r_valid <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_addr[r_wptr]  <= c_waddr;
                r_data[r_wptr]  <= c_wdata;
                r_strb[r_wptr]  <= c_wstrb;
                r_valid[r_wptr] <= 1'b1;
                r_wptr          <= r_wptr + c_PW'(1);
            end
            if (w_deq) begin
                r_valid[r_rptr] <= 1'b0;
                r_rptr          <= r_rptr + c_PW'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_srv32_dmem_wbuf.sv
// ============================================================================
//  Module      : tb_srv32_dmem_wbuf
//  Description : Scoreboard bench for srv32_dmem_wbuf with a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_srv32_dmem_wbuf;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        c_wreq = 1'b0, c_rreq = 1'b0, m_wack = 1'b0, m_rack = 1'b0, m_rvalid = 1'b0;
    logic [31:0] c_waddr = '0, c_wdata = '0, c_raddr = '0, m_rdata = '0;
    logic [3:0]  c_wstrb = '0;
    logic        c_wack, c_rack, c_rvalid, m_wreq, m_rreq, wbuf_empty;
    logic [31:0] c_rdata, m_waddr, m_wdata, m_raddr;
    logic [3:0]  m_wstrb;
    logic [2:0]  wbuf_count;

    int total = 0;
    int bad   = 0;
    ent_t model_q[$];
    ent_t sb_q[$];

    srv32_dmem_wbuf #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .c_wreq(c_wreq), .c_wack(c_wack), .c_waddr(c_waddr), .c_wdata(c_wdata), .c_wstrb(c_wstrb),
        .c_rreq(c_rreq), .c_rack(c_rack), .c_raddr(c_raddr), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .m_wreq(m_wreq), .m_wack(m_wack), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rreq(m_rreq), .m_rack(m_rack), .m_raddr(m_raddr), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .wbuf_count(wbuf_count), .wbuf_empty(wbuf_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check against the model, then advance the model.
    task automatic step(input logic wr, input logic [31:0] wa, input logic [31:0] wd,
                        input logic [3:0] ws, input logic rr, input logic [31:0] ra,
                        input logic mwa, input logic mra);
        logic exp_wack, exp_wreq, haz, exp_rreq;
        ent_t e;
        @(negedge clk);
        c_wreq = wr; c_waddr = wa; c_wdata = wd; c_wstrb = ws;
        c_rreq = rr; c_raddr = ra; m_wack = mwa; m_rack = mra;
        m_rvalid = 1'($urandom); m_rdata = $urandom;
        #1;
        exp_wack = (model_q.size() != DEPTH);
        exp_wreq = (model_q.size() != 0);
        haz = wr && exp_wack && (wa[31:2] == ra[31:2]);
        foreach (model_q[i]) if (model_q[i].a[31:2] == ra[31:2]) haz = 1'b1;
        exp_rreq = rr && !haz;
        chk("c_wack", 32'(c_wack), 32'(exp_wack));
        chk("m_wreq", 32'(m_wreq), 32'(exp_wreq));
        chk("wbuf_count", 32'(wbuf_count), model_q.size());
        chk("wbuf_empty", 32'(wbuf_empty), 32'(model_q.size() == 0));
        chk("m_rreq", 32'(m_rreq), 32'(exp_rreq));
        chk("c_rack", 32'(c_rack), 32'(exp_rreq && mra));
        chk("m_raddr", m_raddr, ra);
        chk("c_rvalid", 32'(c_rvalid), 32'(m_rvalid));
        chk("c_rdata", c_rdata, m_rdata);
        if (exp_wreq) chk("head_addr", m_waddr, model_q[0].a);
        if (exp_wreq && mwa) void'(model_q.pop_front());
        if (wr && exp_wack) begin
            e.a = wa; e.d = wd; e.s = ws;
            model_q.push_back(e);
            sb_q.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic idle(input logic mwa, input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, '0, mwa, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        c_wreq = 1'b0; c_rreq = 1'b0; m_wack = 1'b0; m_rack = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_c_wack", 32'(c_wack), 32'd1);
        chk("rst_m_wreq", 32'(m_wreq), 32'd0);
        chk("rst_count", 32'(wbuf_count), 32'd0);
        chk("rst_empty", 32'(wbuf_empty), 32'd1);
        chk("rst_m_waddr", m_waddr, 32'd0);
        chk("rst_m_rreq", 32'(m_rreq), 32'd0);
        model_q.delete();
        sb_q.delete();
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    // Monitor: every write the memory accepts must be the oldest expected store.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!reset && m_wreq && m_wack) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL mem_write: unexpected write addr=%h data=%h", m_waddr, m_wdata);
                end else begin
                    e = sb_q.pop_front();
                    chk("mem_addr", m_waddr, e.a);
                    chk("mem_data", m_wdata, e.d);
                    chk("mem_strb", 32'(m_wstrb), 32'(e.s));
                end
            end
        end
    end

    initial begin
        logic [31:0] wa, ra;
        do_reset();

        // Fill to full with memory stalled, then drain and refill.
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h100 + 32'(i * 4), 32'hA0 + 32'(i), 4'hF, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 32'h110, 32'hA4, 4'hF, 1'b0, '0, 1'b0, 1'b0);
        chk("full_wack", 32'(c_wack), 32'd0);
        chk("full_count", 32'(wbuf_count), 32'd4);
        step(1'b1, 32'h110, 32'hA4, 4'hF, 1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 32'h110, 32'hA4, 4'hF, 1'b0, '0, 1'b1, 1'b0);
        idle(1'b1, 6);

        // Steady occupancy of two with simultaneous enqueue/dequeue across the wrap.
        for (int i = 1; i <= 10; i++)
            step(1'b1, 32'h400 + 32'(i * 4), 32'(i), 4'(i), 1'b0, '0, (i > 2), 1'b0);
        chk("wrap_count", 32'(wbuf_count), 32'd2);
        idle(1'b1, 4);

        // Load hazard against a pending byte store.
        step(1'b1, 32'h200, 32'h55, 4'b0001, 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 32'h203, 1'b0, 1'b1);
        step(1'b0, '0, '0, '0, 1'b1, 32'h204, 1'b0, 1'b1);
        step(1'b0, '0, '0, '0, 1'b1, 32'h203, 1'b1, 1'b1);
        step(1'b0, '0, '0, '0, 1'b1, 32'h203, 1'b0, 1'b1);
        chk("haz_release", 32'(m_rreq), 32'd1);

        // Store and load to the same word in the same cycle.
        step(1'b1, 32'h300, 32'h77, 4'hF, 1'b1, 32'h300, 1'b0, 1'b1);
        step(1'b0, '0, '0, '0, 1'b1, 32'h300, 1'b0, 1'b1);
        step(1'b0, '0, '0, '0, 1'b1, 32'h300, 1'b1, 1'b1);
        step(1'b0, '0, '0, '0, 1'b1, 32'h300, 1'b0, 1'b1);

        // Reset mid-drain discards pending stores.
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h500 + 32'(i * 4), 32'hB0 + 32'(i), 4'hF, 1'b0, '0, 1'b0, 1'b0);
        do_reset();
        idle(1'b1, 5);

        // Randomised traffic over a small address window to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            wa = 32'h600 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            ra = 32'h600 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            step(1'($urandom), wa, $urandom, 4'($urandom), 1'($urandom), ra,
                 ($urandom_range(0, 2) != 0), 1'($urandom));
        end
        idle(1'b1, 8);
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
